// File: rtl/internalram_pkg.sv
// Shared types and constants for the internal BRAM sequencer.
// State and grant encodings live here so the top and any checker agree on them.
package internalram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RD_WAIT     = 3'd1,
        ST_RMW_WR      = 3'd2,
        ST_CPU_HOLD    = 3'd3,
        ST_CPU_RELEASE = 3'd4
    } state_t;

    typedef enum logic {
        GRANT_CPU    = 1'b0,
        GRANT_LOADER = 1'b1
    } grant_t;

    localparam int RAM_RD_LATENCY = 1;

    // RD_WAIT spans the enable cycle plus the RAM read latency
    localparam logic [1:0] RD_WAIT_LAST = 2'(RAM_RD_LATENCY);

    function automatic logic is_partial_write(input logic uds, input logic lds);
        return uds ^ lds;
    endfunction

endpackage

// File: rtl/internalram_ctrl_merge.sv
// Byte-lane merge for read-modify-write: strobed lanes come from the new
// write data, unstrobed lanes keep the word just read from the RAM.
module internalram_ctrl_merge
    import internalram_pkg::*;
(
    input  logic        i_uds,
    input  logic        i_lds,
    input  logic [15:0] i_wdata,
    input  logic [15:0] i_rdata,
    output logic [15:0] o_merged
);

    logic [7:0] w_hi;
    logic [7:0] w_lo;

    // Select each lane independently
    always_comb begin
        w_hi = i_rdata[15:8];
        w_lo = i_rdata[7:0];
        if (i_uds) begin
            w_hi = i_wdata[15:8];
        end else begin
            w_hi = i_rdata[15:8];
        end
        if (i_lds) begin
            w_lo = i_wdata[7:0];
        end else begin
            w_lo = i_rdata[7:0];
        end
    end

    assign o_merged = {w_hi, w_lo};

endmodule

// File: rtl/internalram_ctrl.sv
// Sequences the internal 16-bit BRAM for the 68000 slave port and the boot loader:
// arbitration, byte-write read-modify-write and DTACK generation. All outputs registered.
module internalram_ctrl
    import internalram_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_sel,
    input  logic              cpu_rw,
    input  logic              cpu_uds,
    input  logic              cpu_lds,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_dtack,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_wdata,
    output logic [15:0]       ld_rdata,
    output logic              ld_ack,
    output logic              ram_enable,
    output logic              ram_write,
    output logic [31:0]       ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata
);

    state_t              r_state;
    grant_t              r_grant;
    grant_t              r_last_grant;
    logic                r_cpu_armed;
    logic                r_rmw;
    logic [1:0]          r_wait;
    logic                r_op_uds;
    logic                r_op_lds;
    logic [15:0]         r_op_wdata;
    logic [15:0]         r_cpu_rdata;
    logic                r_cpu_dtack;
    logic [15:0]         r_ld_rdata;
    logic                r_ld_ack;
    logic                r_ram_enable;
    logic                r_ram_write;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [15:0]         r_ram_wdata;

    logic                w_cpu_pend;
    logic                w_ld_pend;
    logic                w_grant_cpu;
    logic                w_grant_ld;
    logic [15:0]         w_merged;

    // A loader request is masked during its own ack cycle so a held ld_req is not re-accepted
    assign w_cpu_pend = cpu_sel & r_cpu_armed;
    assign w_ld_pend  = ld_req & ~r_ld_ack;

    // Round-robin tie break: the requester not granted last time wins
    always_comb begin
        w_grant_cpu = 1'b0;
        w_grant_ld  = 1'b0;
        if (w_cpu_pend && w_ld_pend) begin
            if (r_last_grant == GRANT_LOADER) begin
                w_grant_cpu = 1'b1;
            end else begin
                w_grant_ld  = 1'b1;
            end
        end else if (w_cpu_pend) begin
            w_grant_cpu = 1'b1;
        end else if (w_ld_pend) begin
            w_grant_ld  = 1'b1;
        end else begin
            w_grant_cpu = 1'b0;
            w_grant_ld  = 1'b0;
        end
    end

    internalram_ctrl_merge u_merge (
        .i_uds    (r_op_uds),
        .i_lds    (r_op_lds),
        .i_wdata  (r_op_wdata),
        .i_rdata  (ram_rdata),
        .o_merged (w_merged)
    );

    // Main sequencer: arbitration, RAM strobes, read capture and handshakes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= GRANT_CPU;
            r_last_grant <= GRANT_LOADER;
            r_cpu_armed  <= 1'b1;
            r_rmw        <= 1'b0;
            r_wait       <= 2'd0;
            r_op_uds     <= 1'b0;
            r_op_lds     <= 1'b0;
            r_op_wdata   <= 16'h0000;
            r_cpu_rdata  <= 16'h0000;
            r_cpu_dtack  <= 1'b0;
            r_ld_rdata   <= 16'h0000;
            r_ld_ack     <= 1'b0;
            r_ram_enable <= 1'b0;
            r_ram_write  <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= 16'h0000;
        end else begin
            r_ram_enable <= 1'b0;
            r_ram_write  <= 1'b0;
            r_ld_ack     <= 1'b0;
            if (!cpu_sel) begin
                r_cpu_armed <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_wait <= 2'd0;
                    r_rmw  <= 1'b0;
                    if (w_grant_cpu) begin
                        r_grant      <= GRANT_CPU;
                        r_last_grant <= GRANT_CPU;
                        r_cpu_armed  <= 1'b0;
                        r_ram_addr   <= cpu_addr;
                        r_op_uds     <= cpu_uds;
                        r_op_lds     <= cpu_lds;
                        r_op_wdata   <= cpu_wdata;
                        if (cpu_rw) begin
                            r_ram_enable <= 1'b1;
                            r_state      <= ST_RD_WAIT;
                        end else if (cpu_uds && cpu_lds) begin
                            r_ram_enable <= 1'b1;
                            r_ram_write  <= 1'b1;
                            r_ram_wdata  <= cpu_wdata;
                            r_state      <= ST_CPU_HOLD;
                        end else if (is_partial_write(cpu_uds, cpu_lds)) begin
                            r_ram_enable <= 1'b1;
                            r_rmw        <= 1'b1;
                            r_state      <= ST_RD_WAIT;
                        end else begin
                            r_state      <= ST_CPU_HOLD;
                        end
                    end else if (w_grant_ld) begin
                        r_grant      <= GRANT_LOADER;
                        r_last_grant <= GRANT_LOADER;
                        r_ram_addr   <= ld_addr;
                        r_ram_enable <= 1'b1;
                        if (ld_we) begin
                            r_ram_write <= 1'b1;
                            r_ram_wdata <= ld_wdata;
                            r_state     <= ST_RMW_WR;
                        end else begin
                            r_state     <= ST_RD_WAIT;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    if (r_wait == RD_WAIT_LAST) begin
                        if (r_grant == GRANT_LOADER) begin
                            r_ld_rdata <= ram_rdata;
                            r_ld_ack   <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else if (r_rmw) begin
                            r_ram_enable <= 1'b1;
                            r_ram_write  <= 1'b1;
                            r_ram_wdata  <= w_merged;
                            r_state      <= ST_RMW_WR;
                        end else begin
                            r_cpu_rdata <= ram_rdata;
                            r_cpu_dtack <= 1'b1;
                            r_state     <= ST_CPU_HOLD;
                        end
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                ST_RMW_WR: begin
                    // Write strobe is in flight this cycle; complete the handshake
                    if (r_grant == GRANT_LOADER) begin
                        r_ld_ack <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_cpu_dtack <= 1'b1;
                        r_state     <= ST_CPU_HOLD;
                    end
                end
                ST_CPU_HOLD: begin
                    if (cpu_sel) begin
                        r_cpu_dtack <= 1'b1;
                    end else begin
                        r_cpu_dtack <= 1'b0;
                        r_state     <= ST_CPU_RELEASE;
                    end
                end
                ST_CPU_RELEASE: begin
                    r_cpu_dtack <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_cpu_dtack <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_dtack  = r_cpu_dtack;
    assign ld_rdata   = r_ld_rdata;
    assign ld_ack     = r_ld_ack;
    assign ram_enable = r_ram_enable;
    assign ram_write  = r_ram_write;
    assign ram_addr   = {{(32-ADDR_W){1'b0}}, r_ram_addr};
    assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_internalram_ctrl.sv
// Self-checking bench for internalram_ctrl with a behavioural synchronous BRAM,
// a shadow memory model and scoreboard queues for CPU and loader read data.
module tb_internalram_ctrl;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_sel, cpu_rw, cpu_uds, cpu_lds;
    logic [ADDR_W-1:0] cpu_addr;
    logic [15:0]       cpu_wdata, cpu_rdata;
    logic              cpu_dtack;
    logic              ld_req, ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [15:0]       ld_wdata, ld_rdata;
    logic              ld_ack;
    logic              ram_enable, ram_write;
    logic [31:0]       ram_addr;
    logic [15:0]       ram_wdata, ram_rdata;

    logic [15:0] ram_mem [0:4095];
    logic [15:0] shadow  [0:4095];
    logic [15:0] cpu_q [$];
    logic [15:0] ld_q  [$];
    int n_checks = 0;
    int n_pass   = 0;
    int ram_acc  = 0;
    int addr_err = 0;

    always #5 clk = ~clk;

    internalram_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .cpu_sel(cpu_sel), .cpu_rw(cpu_rw), .cpu_uds(cpu_uds), .cpu_lds(cpu_lds),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_dtack(cpu_dtack),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ack(ld_ack),
        .ram_enable(ram_enable), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Synchronous single-port RAM: read data valid one cycle after enable
    always @(posedge clk) begin
        if (ram_enable) begin
            ram_acc <= ram_acc + 1;
            if (ram_addr[31:12] != 20'd0) addr_err <= addr_err + 1;
            if (ram_write) ram_mem[ram_addr[11:0]] <= ram_wdata;
            else           ram_rdata <= ram_mem[ram_addr[11:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_cpu(input logic rw, input logic uds, input logic lds,
                             input logic [11:0] addr, input logic [15:0] wdata);
        if (rw) begin
            cpu_q.push_back(shadow[addr]);
        end else begin
            if (uds) shadow[addr][15:8] = wdata[15:8];
            if (lds) shadow[addr][7:0]  = wdata[7:0];
        end
    endtask

    task automatic model_ld(input logic we, input logic [11:0] addr, input logic [15:0] wdata);
        if (we) shadow[addr] = wdata;
        else    ld_q.push_back(shadow[addr]);
    endtask

    task automatic cpu_access(input logic rw, input logic uds, input logic lds,
                              input logic [11:0] addr, input logic [15:0] wdata,
                              input int exp_lat, input int hold, input int exp_acc);
        int lat;
        int acc0;
        logic [15:0] e;
        @(posedge clk); #1;
        acc0 = ram_acc;
        cpu_rw = rw; cpu_uds = uds; cpu_lds = lds; cpu_addr = addr; cpu_wdata = wdata;
        cpu_sel = 1'b1;
        model_cpu(rw, uds, lds, addr, wdata);
        lat = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
        end while (!cpu_dtack && lat < 40);
        check("cpu_dtack_latency", lat, exp_lat);
        if (rw && cpu_q.size() > 0) begin
            e = cpu_q.pop_front();
            check("cpu_rdata", {16'h0, cpu_rdata}, {16'h0, e});
        end
        repeat (hold) @(negedge clk);
        if (hold > 0) check("cpu_dtack_held", {31'h0, cpu_dtack}, 32'h1);
        cpu_sel = 1'b0;
        @(negedge clk);
        check("cpu_dtack_release", {31'h0, cpu_dtack}, 32'h0);
        @(negedge clk);
        check("cpu_ram_accesses", ram_acc - acc0, exp_acc);
    endtask

    task automatic ld_access(input logic we, input logic [11:0] addr, input logic [15:0] wdata,
                             input int exp_lat);
        int lat;
        logic [15:0] e;
        @(posedge clk); #1;
        ld_we = we; ld_addr = addr; ld_wdata = wdata; ld_req = 1'b1;
        model_ld(we, addr, wdata);
        lat = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
        end while (!ld_ack && lat < 40);
        ld_req = 1'b0;
        check("ld_ack_latency", lat, exp_lat);
        if (!we && ld_q.size() > 0) begin
            e = ld_q.pop_front();
            check("ld_rdata", {16'h0, ld_rdata}, {16'h0, e});
        end
        @(negedge clk);
        check("ld_ack_one_cycle", {31'h0, ld_ack}, 32'h0);
    endtask

    task automatic tie_access(input logic c_rw, input logic c_uds, input logic c_lds,
                              input logic [11:0] c_addr, input logic [15:0] c_wdata,
                              input logic l_we, input logic [11:0] l_addr, input logic [15:0] l_wdata,
                              input int exp_c, input int exp_l);
        int k;
        int t_c;
        int t_l;
        logic [15:0] e;
        @(posedge clk); #1;
        cpu_rw = c_rw; cpu_uds = c_uds; cpu_lds = c_lds; cpu_addr = c_addr; cpu_wdata = c_wdata;
        ld_we = l_we; ld_addr = l_addr; ld_wdata = l_wdata;
        cpu_sel = 1'b1; ld_req = 1'b1;
        model_cpu(c_rw, c_uds, c_lds, c_addr, c_wdata);
        model_ld(l_we, l_addr, l_wdata);
        k = 0; t_c = 0; t_l = 0;
        while ((t_c == 0 || t_l == 0) && k < 60) begin
            @(posedge clk); k++;
            @(negedge clk);
            if (cpu_dtack && t_c == 0) begin
                t_c = k;
                if (c_rw && cpu_q.size() > 0) begin
                    e = cpu_q.pop_front();
                    check("tie_cpu_rdata", {16'h0, cpu_rdata}, {16'h0, e});
                end
                cpu_sel = 1'b0;
            end
            if (ld_ack && t_l == 0) begin
                t_l = k;
                if (!l_we && ld_q.size() > 0) begin
                    e = ld_q.pop_front();
                    check("tie_ld_rdata", {16'h0, ld_rdata}, {16'h0, e});
                end
                ld_req = 1'b0;
            end
        end
        check("tie_cpu_latency", t_c, exp_c);
        check("tie_ld_latency", t_l, exp_l);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int acc0;
        for (int i = 0; i < 4096; i++) shadow[i] = 16'h0000;
        reset = 1'b1;
        cpu_sel = 1'b0; cpu_rw = 1'b1; cpu_uds = 1'b0; cpu_lds = 1'b0;
        cpu_addr = '0; cpu_wdata = 16'h0000;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {28'h0, cpu_dtack, ld_ack, ram_enable, ram_write}, 32'h0);
        check("reset_rdata", {cpu_rdata, ld_rdata}, 32'h0);
        check("reset_ram_addr", ram_addr, 32'h0);
        check("reset_ram_wdata", {16'h0, ram_wdata}, 32'h0);
        reset = 1'b0;

        // Tie straight out of reset: CPU (no-strobe write) first, then loader write
        acc0 = ram_acc;
        tie_access(1'b0, 1'b0, 1'b0, 12'h000, 16'hFFFF, 1'b1, 12'h010, 16'h1234, 2, 6);
        check("tie1_ram_accesses", ram_acc - acc0, 1);
        check("tie1_mem", {16'h0, ram_mem[12'h010]}, 32'h1234);

        cpu_access(1'b1, 1'b1, 1'b1, 12'h010, 16'h0000, 3, 3, 1);

        // Byte-lane read-modify-write
        ld_access(1'b1, 12'h020, 16'hAABB, 2);
        cpu_access(1'b0, 1'b1, 1'b0, 12'h020, 16'h55EE, 4, 0, 2);
        check("rmw_uds_mem", {16'h0, ram_mem[12'h020]}, 32'h55BB);
        cpu_access(1'b0, 1'b0, 1'b1, 12'h020, 16'h9966, 4, 0, 2);
        check("rmw_lds_mem", {16'h0, ram_mem[12'h020]}, 32'h5566);
        cpu_access(1'b1, 1'b1, 1'b1, 12'h020, 16'h0000, 3, 0, 1);

        cpu_access(1'b0, 1'b1, 1'b1, 12'h050, 16'h0F0F, 2, 0, 1);
        cpu_access(1'b1, 1'b1, 1'b1, 12'h050, 16'h0000, 3, 0, 1);

        // CPU was granted last, so the loader wins these ties
        tie_access(1'b1, 1'b1, 1'b1, 12'h020, 16'h0000, 1'b0, 12'h010, 16'h0000, 6, 3);
        tie_access(1'b1, 1'b1, 1'b1, 12'h010, 16'h0000, 1'b1, 12'h040, 16'hBEEF, 5, 2);

        // Long AS: one access only, no re-accept while sel stays high
        cpu_access(1'b1, 1'b1, 1'b1, 12'h040, 16'h0000, 3, 10, 1);

        // No strobes: DTACK without touching the RAM
        cpu_access(1'b0, 1'b0, 1'b0, 12'h040, 16'hFFFF, 2, 0, 0);
        check("nostrobe_mem", {16'h0, ram_mem[12'h040]}, 32'hBEEF);
        ld_access(1'b0, 12'h020, 16'h0000, 3);

        // Reset while the byte write waits for its read data
        ld_access(1'b1, 12'h030, 16'hCAFE, 2);
        @(posedge clk); #1;
        cpu_rw = 1'b0; cpu_uds = 1'b1; cpu_lds = 1'b0; cpu_addr = 12'h030; cpu_wdata = 16'h1100;
        cpu_sel = 1'b1;
        @(posedge clk); #1;
        check("rmw_read_issued", {31'h0, ram_enable}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midop_reset_ctrl", {28'h0, cpu_dtack, ld_ack, ram_enable, ram_write}, 32'h0);
        check("midop_reset_rdata", {cpu_rdata, ld_rdata}, 32'h0);
        check("midop_reset_ram_bus", ram_addr | {16'h0, ram_wdata}, 32'h0);
        cpu_sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midop_reset_mem", {16'h0, ram_mem[12'h030]}, 32'hCAFE);
        ld_access(1'b0, 12'h030, 16'h0000, 3);
        cpu_access(1'b1, 1'b1, 1'b1, 12'h030, 16'h0000, 3, 0, 1);

        check("cpu_queue_empty", cpu_q.size(), 0);
        check("ld_queue_empty", ld_q.size(), 0);
        check("ram_addr_upper_zero", addr_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
